// File: rtl/spike_train_monitor.sv
// Spike train monitor: turns a level spike into edge-detected, refractory-gated events,
// reporting a per-window spike count over valid/ready and inter-spike intervals.
module spike_train_monitor #(
  parameter int WIN_W = 16,
  parameter int CNT_W = 8,
  parameter int ISI_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             spike,
  input  logic             enable,
  input  logic [WIN_W-1:0] window_len,
  input  logic [7:0]       refractory,
  output logic             event_pulse,
  output logic [CNT_W-1:0] rate_count,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic [ISI_W-1:0] isi,
  output logic             isi_valid,
  output logic             sat_flag,
  output logic             drop_flag
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_COUNT = 1'b1;

  localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
  localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [ISI_W-1:0] ISI_ZERO = {ISI_W{1'b0}};
  localparam logic [ISI_W-1:0] ISI_ONE  = {{(ISI_W-1){1'b0}}, 1'b1};
  localparam logic [ISI_W-1:0] ISI_MAX  = {ISI_W{1'b1}};

  logic [0:0]       r_state;
  logic             r_spike_d;
  logic [7:0]       r_refr_cnt;
  logic             r_event_pulse;
  logic [WIN_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_spike_cnt;
  logic [CNT_W-1:0] r_rate_count;
  logic             r_rate_valid;
  logic [ISI_W-1:0] r_isi_tmr;
  logic [ISI_W-1:0] r_isi;
  logic             r_isi_valid;
  logic             r_first_seen;
  logic             r_sat_flag;
  logic             r_drop_flag;

  logic             w_accept;
  logic             w_counting;
  logic             w_close;
  logic             w_handshake;
  logic             w_tmr_sat;
  logic             w_cnt_ovf;
  logic [CNT_W-1:0] w_cnt_next;
  logic [WIN_W-1:0] w_win_load;

  assign w_accept    = spike & ~r_spike_d & enable & (r_refr_cnt == 8'd0);
  assign w_counting  = (r_state == S_COUNT) & enable;
  assign w_close     = w_counting & (r_win_cnt == WIN_ZERO);
  assign w_handshake = r_rate_valid & rate_ready;
  assign w_tmr_sat   = (r_isi_tmr == ISI_MAX);

  // Saturating window count including any event accepted this cycle, plus reload value
  always_comb begin
    w_cnt_next = r_spike_cnt;
    w_cnt_ovf  = 1'b0;
    w_win_load = WIN_ZERO;
    if (w_accept) begin
      if (r_spike_cnt == CNT_MAX) begin
        w_cnt_ovf = w_counting;
      end else begin
        w_cnt_next = r_spike_cnt + CNT_ONE;
      end
    end else begin
      w_cnt_next = r_spike_cnt;
    end
    if (window_len == WIN_ZERO) begin
      w_win_load = WIN_ZERO;
    end else begin
      w_win_load = window_len - WIN_ONE;
    end
  end

  // Edge detection, refractory lockout and the registered event pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_spike_d     <= 1'b0;
      r_refr_cnt    <= 8'd0;
      r_event_pulse <= 1'b0;
    end else begin
      r_spike_d     <= spike;
      r_event_pulse <= w_accept;
      if (w_accept) begin
        r_refr_cnt <= refractory;
      end else if (r_refr_cnt != 8'd0) begin
        r_refr_cnt <= r_refr_cnt - 8'd1;
      end
    end
  end

  // Window FSM: back-to-back windows while enabled, partial window dropped on disable
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_win_cnt   <= WIN_ZERO;
      r_spike_cnt <= CNT_ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state     <= S_COUNT;
            r_win_cnt   <= w_win_load;
            r_spike_cnt <= CNT_ZERO;
          end
        end
        S_COUNT: begin
          if (!enable) begin
            r_state     <= S_IDLE;
            r_win_cnt   <= WIN_ZERO;
            r_spike_cnt <= CNT_ZERO;
          end else if (r_win_cnt == WIN_ZERO) begin
            r_win_cnt   <= w_win_load;
            r_spike_cnt <= CNT_ZERO;
          end else begin
            r_win_cnt   <= r_win_cnt - WIN_ONE;
            r_spike_cnt <= w_cnt_next;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_win_cnt   <= WIN_ZERO;
          r_spike_cnt <= CNT_ZERO;
        end
      endcase
    end
  end

  // Rate output holding register; a closing window may reuse the slot being consumed
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rate_count <= CNT_ZERO;
      r_rate_valid <= 1'b0;
    end else if (w_close && (!r_rate_valid || rate_ready)) begin
      r_rate_count <= w_cnt_next;
      r_rate_valid <= 1'b1;
    end else if (w_handshake) begin
      r_rate_valid <= 1'b0;
    end
  end

  // Inter-spike interval timer and reporting
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_isi_tmr    <= ISI_ZERO;
      r_isi        <= ISI_ZERO;
      r_isi_valid  <= 1'b0;
      r_first_seen <= 1'b0;
    end else if (w_accept) begin
      r_isi_tmr    <= ISI_ONE;
      r_first_seen <= 1'b1;
      r_isi_valid  <= r_first_seen;
      if (r_first_seen) begin
        r_isi <= r_isi_tmr;
      end
    end else begin
      r_isi_valid <= 1'b0;
      if (!w_tmr_sat) begin
        r_isi_tmr <= r_isi_tmr + ISI_ONE;
      end
      if (!enable) begin
        r_first_seen <= 1'b0;
      end
    end
  end

  // Sticky saturation and drop indicators
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sat_flag  <= 1'b0;
      r_drop_flag <= 1'b0;
    end else begin
      if (w_cnt_ovf || (w_tmr_sat && !w_accept)) begin
        r_sat_flag <= 1'b1;
      end
      if (w_close && r_rate_valid && !rate_ready) begin
        r_drop_flag <= 1'b1;
      end
    end
  end

  assign event_pulse = r_event_pulse;
  assign rate_count  = r_rate_count;
  assign rate_valid  = r_rate_valid;
  assign isi         = r_isi;
  assign isi_valid   = r_isi_valid;
  assign sat_flag    = r_sat_flag;
  assign drop_flag   = r_drop_flag;

endmodule
